// File: rtl/instr_encoder_if.sv
// Field-bundle in / encoded-word out bus of the RV32I instruction encoder,
// plus the start pulse and status counters.
interface instr_encoder_if #(
  parameter int ADDR_W   = 12,
  parameter int ERRCNT_W = 8
);
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          in_fmt;
  logic [6:0]          in_opcode;
  logic [4:0]          in_rd;
  logic [4:0]          in_rs1;
  logic [4:0]          in_rs2;
  logic [2:0]          in_funct3;
  logic [6:0]          in_funct7;
  logic [31:0]         in_imm;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_instr;
  logic [ADDR_W-1:0]   out_addr;
  logic                err_sticky;
  logic [ERRCNT_W-1:0] err_count;
  logic [ADDR_W-1:0]   word_count;

  modport master (
    output start, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err_sticky, err_count,
           word_count
  );

  modport slave (
    input  start, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err_sticky, err_count,
           word_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I field bundles into instruction words with sequential byte
// addresses; illegal bundles are consumed and counted instead of emitted.
module instr_encoder #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int ERRCNT_W  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_encoder_if.slave bus
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
    FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
  } fmt_e;

  logic                r_out_valid;
  logic [31:0]         r_out_instr;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_word_count;
  logic                r_err_sticky;
  logic [ERRCNT_W-1:0] r_err_count;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_legal;
  logic [31:0] w_instr;
  logic [31:0] w_imm;

  assign w_imm      = bus.in_imm;
  assign w_in_ready = !bus.start && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // Range checks: the immediate must survive truncation to the bits the
  // format actually stores, i.e. the upper bits are a pure sign extension.
  always_comb begin
    w_legal = 1'b0;
    w_instr = 32'd0;
    case (bus.in_fmt)
      FMT_R: begin
        w_legal = 1'b1;
        w_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   bus.in_rd, bus.in_opcode};
      end
      FMT_I: begin
        w_legal = (w_imm[31:11] == {21{w_imm[11]}});
        w_instr = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                   bus.in_opcode};
      end
      FMT_S: begin
        w_legal = (w_imm[31:11] == {21{w_imm[11]}});
        w_instr = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   w_imm[4:0], bus.in_opcode};
      end
      FMT_B: begin
        w_legal = (w_imm[31:12] == {20{w_imm[12]}}) && !w_imm[0];
        w_instr = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1,
                   bus.in_funct3, w_imm[4:1], w_imm[11], bus.in_opcode};
      end
      FMT_U: begin
        w_legal = (w_imm[11:0] == 12'd0);
        w_instr = {w_imm[31:12], bus.in_rd, bus.in_opcode};
      end
      FMT_J: begin
        w_legal = (w_imm[31:20] == {12{w_imm[20]}}) && !w_imm[0];
        w_instr = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                   bus.in_rd, bus.in_opcode};
      end
      default: begin
        w_legal = 1'b0;
        w_instr = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= 32'd0;
      r_out_addr   <= '0;
      r_ptr        <= BASE;
      r_word_count <= '0;
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else begin
      if (r_out_valid && bus.out_ready)
        r_out_valid <= 1'b0;
      if (w_accept && w_legal) begin
        r_out_valid  <= 1'b1;
        r_out_instr  <= w_instr;
        r_out_addr   <= r_ptr;
        r_ptr        <= r_ptr + ADDR_W'(4);
        r_word_count <= r_word_count + ADDR_W'(1);
      end
      if (w_accept && !w_legal) begin
        r_err_sticky <= 1'b1;
        if (r_err_count != '1)
          r_err_count <= r_err_count + ERRCNT_W'(1);
      end
      // start never coincides with an accept (in_ready is low), and leaves
      // any held output word alone so it drains with its old address.
      if (bus.start) begin
        r_ptr        <= BASE;
        r_word_count <= '0;
        r_err_sticky <= 1'b0;
        r_err_count  <= '0;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_instr  = r_out_instr;
  assign bus.out_addr   = r_out_addr;
  assign bus.err_sticky = r_err_sticky;
  assign bus.err_count  = r_err_count;
  assign bus.word_count = r_word_count;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 4-bit address space so pointer
// wrap is reached quickly; expected words are hand-encoded constants.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(4), .ERRCNT_W(8)) bus();

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(0), .ERRCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    bus.in_valid  = 1'b1;
    bus.in_fmt    = f;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.out_instr); end
    checks++; if (bus.out_addr !== 4'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.out_addr); end
    checks++; if (bus.err_count !== 8'd0 || bus.err_sticky !== 1'b0) begin failures++; $display("FAIL reset_err got=%0d/%b exp=0/0", bus.err_count, bus.err_sticky); end
    checks++; if (bus.word_count !== 4'd0) begin failures++; $display("FAIL reset_wc got=%0d exp=0", bus.word_count); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_rsi;
    bus.out_ready = 1'b1;
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h002081B3 || bus.out_addr !== 4'd0) begin failures++; $display("FAIL r_add got=%b %h @%0d exp=1 002081b3 @0", bus.out_valid, bus.out_instr, bus.out_addr); end
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00500093 || bus.out_addr !== 4'd4) begin failures++; $display("FAIL i_addi got=%b %h @%0d exp=1 00500093 @4", bus.out_valid, bus.out_instr, bus.out_addr); end
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0020A423 || bus.out_addr !== 4'd8) begin failures++; $display("FAIL s_sw got=%b %h @%0d exp=1 0020a423 @8", bus.out_valid, bus.out_instr, bus.out_addr); end
    bus.in_valid = 1'b0; tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.word_count !== 4'd3) begin failures++; $display("FAIL rsi_drain got=%b wc=%0d exp=0 wc=3", bus.out_valid, bus.word_count); end
  endtask

  task automatic test_bju;
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4); tick();
    checks++; if (bus.out_instr !== 32'hFE208EE3 || bus.out_addr !== 4'd12) begin failures++; $display("FAIL b_beq got=%h @%0d exp=fe208ee3 @12", bus.out_instr, bus.out_addr); end
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000); tick();
    checks++; if (bus.out_instr !== 32'h123452B7 || bus.out_addr !== 4'd0) begin failures++; $display("FAIL u_lui got=%h @%0d exp=123452b7 @0", bus.out_instr, bus.out_addr); end
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8); tick();
    checks++; if (bus.out_instr !== 32'h008000EF || bus.out_addr !== 4'd4) begin failures++; $display("FAIL j_jal got=%h @%0d exp=008000ef @4", bus.out_instr, bus.out_addr); end
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094); tick();
    checks++; if (bus.out_instr !== 32'h7E000FE3 || bus.out_addr !== 4'd8) begin failures++; $display("FAIL b_max got=%h @%0d exp=7e000fe3 @8", bus.out_instr, bus.out_addr); end
    bus.in_valid = 1'b0; tick();
    checks++; if (bus.word_count !== 4'd7) begin failures++; $display("FAIL bju_wc got=%0d exp=7", bus.word_count); end
  endtask

  task automatic test_errors;
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3); tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL err_b_odd valid got=%b exp=0", bus.out_valid); end
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001); tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL err_u_low valid got=%b exp=0", bus.out_valid); end
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048); tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL err_i_range valid got=%b exp=0", bus.out_valid); end
    send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0); tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL err_fmt6 valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.err_count !== 8'd4 || bus.err_sticky !== 1'b1 || bus.word_count !== 4'd7) begin failures++; $display("FAIL err_counts got=%0d/%b wc=%0d exp=4/1 wc=7", bus.err_count, bus.err_sticky, bus.word_count); end
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00500093 || bus.out_addr !== 4'd12) begin failures++; $display("FAIL err_next got=%b %h @%0d exp=1 00500093 @12", bus.out_valid, bus.out_instr, bus.out_addr); end
    bus.in_valid = 1'b0; tick();
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1); tick();
    send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2); tick(); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00100113 || bus.out_addr !== 4'd0) begin failures++; $display("FAIL bp_hold got=%b %h @%0d exp=1 00100113 @0", bus.out_valid, bus.out_instr, bus.out_addr); end
    checks++; if (bus.in_ready !== 1'b0 || bus.word_count !== 4'd9) begin failures++; $display("FAIL bp_stall ready=%b wc=%0d exp=0 wc=9", bus.in_ready, bus.word_count); end
    bus.out_ready = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready got=%b exp=1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00200193 || bus.out_addr !== 4'd4) begin failures++; $display("FAIL bp_second got=%b %h @%0d exp=1 00200193 @4", bus.out_valid, bus.out_instr, bus.out_addr); end
    bus.in_valid = 1'b0; tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 4'd4 || bus.word_count !== 4'd10) begin failures++; $display("FAIL bp_drain got=%b @%0d wc=%0d exp=0 @4 wc=10", bus.out_valid, bus.out_addr, bus.word_count); end
  endtask

  task automatic test_err_saturate;
    send(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int i = 0; i < 260; i++) tick();
    bus.in_valid = 1'b0; tick();
    checks++; if (bus.err_count !== 8'hFF || bus.err_sticky !== 1'b1) begin failures++; $display("FAIL err_sat got=%0d/%b exp=255/1", bus.err_count, bus.err_sticky); end
  endtask

  task automatic test_start_wrap;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    checks++; if (bus.word_count !== 4'd0 || bus.err_count !== 8'd0 || bus.err_sticky !== 1'b0) begin failures++; $display("FAIL start_clear wc=%0d err=%0d/%b exp=0 0/0", bus.word_count, bus.err_count, bus.err_sticky); end
    for (int k = 0; k < 5; k++) begin
      logic [3:0]  ea;
      logic [31:0] ei;
      ea = 4'(4 * k);
      ei = (32'(k) << 20) | 32'h00000093;
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k)); tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== ei || bus.out_addr !== ea) begin failures++; $display("FAIL wrap_%0d got=%b %h @%0d exp=1 %h @%0d", k, bus.out_valid, bus.out_instr, bus.out_addr, ei, ea); end
    end
    bus.in_valid = 1'b0; tick();
    checks++; if (bus.word_count !== 4'd5) begin failures++; $display("FAIL wrap_wc got=%0d exp=5", bus.word_count); end
    send(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0); tick();
    bus.out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7); tick();
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    bus.start = 1'b1; bus.out_ready = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL start_ready got=%b exp=0", bus.in_ready); end
    bus.out_ready = 1'b0;
    tick(); bus.start = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00700093 || bus.out_addr !== 4'd4) begin failures++; $display("FAIL start_held got=%b %h @%0d exp=1 00700093 @4", bus.out_valid, bus.out_instr, bus.out_addr); end
    checks++; if (bus.err_count !== 8'd0 || bus.err_sticky !== 1'b0 || bus.word_count !== 4'd0) begin failures++; $display("FAIL start_counts err=%0d/%b wc=%0d exp=0/0 wc=0", bus.err_count, bus.err_sticky, bus.word_count); end
    bus.out_ready = 1'b1; tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00900093 || bus.out_addr !== 4'd0 || bus.word_count !== 4'd1) begin failures++; $display("FAIL start_next got=%b %h @%0d wc=%0d exp=1 00900093 @0 wc=1", bus.out_valid, bus.out_instr, bus.out_addr, bus.word_count); end
    bus.in_valid = 1'b0; tick();
  endtask

  task automatic test_reset_mid;
    send(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0); tick();
    bus.out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 4'd4 || bus.err_count !== 8'd1) begin failures++; $display("FAIL rst_pre got=%b @%0d err=%0d exp=1 @4 err=1", bus.out_valid, bus.out_addr, bus.err_count); end
    rst_n = 1'b0; tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.err_count !== 8'd0 || bus.word_count !== 4'd0 || bus.out_instr !== 32'd0) begin failures++; $display("FAIL rst_mid got=%b err=%0d wc=%0d %h exp=0 0 0 0", bus.out_valid, bus.err_count, bus.word_count, bus.out_instr); end
    rst_n = 1'b1; bus.out_ready = 1'b1; tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00300093 || bus.out_addr !== 4'd0) begin failures++; $display("FAIL rst_next got=%b %h @%0d exp=1 00300093 @0", bus.out_valid, bus.out_instr, bus.out_addr); end
    bus.in_valid = 1'b0; tick();
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_fmt = '0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;
    test_reset();
    test_rsi();
    test_bju();
    test_errors();
    test_backpressure();
    test_err_saturate();
    test_start_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
